// File: rtl/cic_decim_strobed.sv
// cic_decim_strobed: programmable-rate CIC decimator feeding the halfband stage.
//
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high reset (also latches rate)
//   enable     - run; low synchronously clears all state and latches rate
//   rate       - decimation factor; 0 -> 1, above 2^MAXLOG2 -> 2^MAXLOG2
//   strobe_in  - input sample valid (may be high every cycle)
//   data_in    - signed input sample
//   strobe_out - one-cycle pulse, decimated sample valid
//   data_out   - signed decimated sample, held between strobes
//
// Latency from the group-completing strobe_in to strobe_out is N+2 cycles:
// capture, N comb stages, normalise.
module cic_decim_strobed #(
  parameter int N       = 4,
  parameter int WIDTH   = 18,
  parameter int MAXLOG2 = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       rate,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             strobe_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int ACC_W = WIDTH + N * MAXLOG2;
  localparam int CNT_W = MAXLOG2 + 1;
  localparam int SH_W  = $clog2(N * MAXLOG2 + 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2 ** (WIDTH - 1)));

  function automatic logic [CNT_W-1:0] clamp_rate(input logic [7:0] r);
    if (r == 8'd0) return CNT_W'(1);
    if (32'(r) > 32'(2 ** MAXLOG2)) return CNT_W'(2 ** MAXLOG2);
    return CNT_W'(r);
  endfunction

  // N * ceil(log2(r))
  function automatic logic [SH_W-1:0] shift_of(input logic [CNT_W-1:0] r);
    int l;
    l = 0;
    for (int i = 0; i <= MAXLOG2; i++)
      if ((32'd1 << i) < 32'(r)) l = i + 1;
    return SH_W'(N * l);
  endfunction

  logic [CNT_W-1:0]        rate_eff;
  logic [SH_W-1:0]         shift_eff;
  logic [CNT_W-1:0]        r_q, r_d, cnt_q, cnt_d;
  logic [SH_W-1:0]         s_q, s_d;
  logic signed [ACC_W-1:0] integ_q [N];
  logic signed [ACC_W-1:0] integ_d [N];
  logic signed [ACC_W-1:0] comb_q  [N];
  logic signed [ACC_W-1:0] comb_d  [N];
  logic signed [ACC_W-1:0] dly_q   [N];
  logic signed [ACC_W-1:0] dly_d   [N];
  logic signed [ACC_W-1:0] samp_q, samp_d;
  logic [N+1:0]            vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic signed [ACC_W-1:0] acc, stage_in;
  logic signed [ACC_W:0]   rnd;

  assign rate_eff   = clamp_rate(rate);
  assign shift_eff  = shift_of(rate_eff);
  assign strobe_out = vld_pipe_q[N+1];
  assign data_out   = data_q;

  always_comb begin
    r_d        = r_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    data_d     = data_q;
    vld_pipe_d = '0;
    for (int k = 0; k < N; k++) begin
      integ_d[k] = integ_q[k];
      comb_d[k]  = comb_q[k];
      dly_d[k]   = dly_q[k];
    end
    acc      = {{(ACC_W-WIDTH){data_in[WIDTH-1]}}, data_in};
    stage_in = samp_q;
    rnd      = '0;

    if (!enable) begin
      r_d    = rate_eff;
      s_d    = shift_eff;
      cnt_d  = '0;
      samp_d = '0;
      data_d = '0;
      for (int k = 0; k < N; k++) begin
        integ_d[k] = '0;
        comb_d[k]  = '0;
        dly_d[k]   = '0;
      end
    end else begin
      // Integrator cascade: each stage sees the previous stage's new value,
      // so the captured sample includes the current input.
      if (strobe_in) begin
        for (int k = 0; k < N; k++) begin
          acc        = integ_q[k] + acc;
          integ_d[k] = acc;
        end
        if (cnt_q == r_q - 1'b1) begin
          cnt_d         = '0;
          samp_d        = acc;
          vld_pipe_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Comb stage k fires when its token sits in vld_pipe_q[k].
      for (int k = 0; k < N; k++) begin
        if (vld_pipe_q[k]) begin
          comb_d[k] = stage_in - dly_q[k];
          dly_d[k]  = stage_in;
        end
        vld_pipe_d[k+1] = vld_pipe_q[k];
        stage_in        = comb_q[k];
      end
      vld_pipe_d[N+1] = vld_pipe_q[N];

      // Normalise: round half up, arithmetic shift, saturate.
      if (vld_pipe_q[N]) begin
        rnd = {comb_q[N-1][ACC_W-1], comb_q[N-1]};
        if (s_q != '0) rnd = rnd + ((ACC_W+1)'(1) <<< (s_q - 1'b1));
        rnd = rnd >>> s_q;
        if (rnd > SAT_HI)      data_d = SAT_HI[WIDTH-1:0];
        else if (rnd < SAT_LO) data_d = SAT_LO[WIDTH-1:0];
        else                   data_d = rnd[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q        <= rate_eff;
      s_q        <= shift_eff;
      cnt_q      <= '0;
      samp_q     <= '0;
      data_q     <= '0;
      vld_pipe_q <= '0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
    end else begin
      r_q        <= r_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      vld_pipe_q <= vld_pipe_d;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_strobed.sv
// Bench for cic_decim_strobed. The reference treats the CIC as its equivalent
// FIR ((1-z^-R)/(1-z^-1))^N applied to all inputs since the last clear,
// sampled every R-th input, then rounded/shifted/saturated.
module tb_cic_decim_strobed;
  localparam int N = 4, W = 18, ML = 7;

  logic         clock = 1'b0;
  logic         reset, enable, strobe_in, strobe_out;
  logic [7:0]   rate;
  logic [W-1:0] data_in, data_out;

  cic_decim_strobed #(.N(N), .WIDTH(W), .MAXLOG2(ML)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rate(rate),
    .strobe_in(strobe_in), .data_in(data_in),
    .strobe_out(strobe_out), .data_out(data_out)
  );

  always #5 clock = ~clock;

  typedef struct { int due; int val; } pend_t;

  int     nchk = 0, nfail = 0, edge_n = 0;
  int     r_lat = 1, held = 0;
  longint h[$];
  longint hist[$];
  pend_t  pend[$];
  int     obs[$];

  function automatic int clamp(int r);
    if (r == 0) return 1;
    if (r > (1 << ML)) return 1 << ML;
    return r;
  endfunction

  function automatic int clog2i(int r);
    int l = 0;
    while ((1 << l) < r) l++;
    return l;
  endfunction

  function automatic void build_h();
    h.delete();
    h.push_back(1);
    repeat (N) begin
      longint nh[$];
      for (int i = 0; i < h.size() + r_lat - 1; i++) begin
        longint s = 0;
        for (int j = 0; j < r_lat; j++)
          if (i - j >= 0 && i - j < h.size()) s += h[i-j];
        nh.push_back(s);
      end
      h = nh;
    end
  endfunction

  function automatic int ref_out();
    longint y = 0;
    int n = hist.size() - 1;
    int s = N * clog2i(r_lat);
    for (int j = 0; j < h.size() && j <= n; j++) y += h[j] * hist[n-j];
    if (s > 0) y += longint'(1) <<< (s - 1);
    y = y >>> s;
    if (y > 131071) y = 131071;
    if (y < -131072) y = -131072;
    return int'(y);
  endfunction

  function automatic void model_edge(bit rst, bit en, bit st, int d);
    edge_n++;
    if (rst || !en) begin
      r_lat = clamp(int'(rate));
      build_h();
      hist.delete();
      pend.delete();
      held = 0;
    end else if (st) begin
      hist.push_back(longint'(d));
      if (hist.size() % r_lat == 0) pend.push_back('{edge_n + N + 1, ref_out()});
    end
  endfunction

  task automatic check_outputs();
    bit exp_s;
    exp_s = (pend.size() > 0) && (pend[0].due == edge_n);
    if (exp_s) begin
      held = pend[0].val;
      void'(pend.pop_front());
    end
    nchk++;
    assert (strobe_out === exp_s) else begin
      nfail++;
      $error("FAIL strobe_out edge=%0d got %b exp %b", edge_n, strobe_out, exp_s);
    end
    nchk++;
    assert (data_out === W'(held)) else begin
      nfail++;
      $error("FAIL data_out edge=%0d got %0d exp %0d", edge_n, $signed(data_out), held);
    end
    if (strobe_out === 1'b1) obs.push_back(int'($signed(data_out)));
  endtask

  task automatic tick(input bit rst, input bit en, input bit st, input int d);
    reset = rst; enable = en; strobe_in = st; data_in = W'(d);
    @(posedge clock);
    model_edge(rst, en, st, d);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input int idx, input int exp);
    int v;
    v = (idx < obs.size()) ? obs[idx] : -999999;
    chk(tag, v, exp);
  endtask

  initial begin
    rate = 8'd4; reset = 1'b1; enable = 1'b0; strobe_in = 1'b0; data_in = '0;

    // reset and idle
    repeat (10) tick(1, 0, 0, 0);
    repeat (20) tick(0, 1, 0, 0);

    // DC, rate 4, strobe every other cycle
    rate = 8'd4; tick(0, 0, 0, 0);
    obs.delete();
    for (int i = 0; i < 80; i++) tick(0, 1, (i % 2) == 0, 1000);
    chk("dc_hold", int'($signed(data_out)), 1000);
    chk_obs("dc_out3", 3, 1000);

    // impulse on index 1, rate 2
    rate = 8'd2; tick(0, 0, 0, 0);
    obs.delete();
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 4096);
    repeat (10) tick(0, 1, 1, 0);
    repeat (8) tick(0, 1, 0, 0);
    chk_obs("imp1_0", 0, 256);
    chk_obs("imp1_1", 1, 1536);
    chk_obs("imp1_2", 2, 256);
    chk_obs("imp1_3", 3, 0);

    // impulse on index 0
    tick(0, 0, 0, 0);
    obs.delete();
    tick(0, 1, 1, 4096);
    repeat (11) tick(0, 1, 1, 0);
    repeat (8) tick(0, 1, 0, 0);
    chk_obs("imp0_0", 0, 1024);
    chk_obs("imp0_1", 1, 1024);
    chk_obs("imp0_2", 2, 0);

    // bypass with rate 1 and rate 0, ramp every cycle
    for (int rr = 1; rr >= 0; rr--) begin
      rate = 8'(rr); tick(0, 0, 0, 0);
      obs.delete();
      for (int i = 0; i < 30; i++) tick(0, 1, 1, i);
      repeat (8) tick(0, 1, 0, 0);
      chk("bypass_count", obs.size(), 30);
    end

    // extremes
    rate = 8'd8; tick(0, 0, 0, 0);
    repeat (80) tick(0, 1, 1, -131072);
    repeat (8) tick(0, 1, 0, 0);
    chk("ext_neg", int'($signed(data_out)), -131072);
    repeat (80) tick(0, 1, 1, 131071);
    repeat (8) tick(0, 1, 0, 0);
    chk("ext_pos", int'($signed(data_out)), 131071);
    rate = 8'd3; tick(0, 0, 0, 0);
    repeat (60) tick(0, 1, 1, 131071);
    repeat (8) tick(0, 1, 0, 0);
    chk("rate3_dc", int'($signed(data_out)), 41472);

    // enable drop mid-group, rate 4 -> 2; later rate changes are ignored
    rate = 8'd4; tick(0, 0, 0, 0);
    obs.delete();
    tick(0, 1, 1, 300);
    tick(0, 1, 1, 300);
    rate = 8'd2; tick(0, 0, 0, 0);
    rate = 8'd4;
    tick(0, 1, 1, 500);
    tick(0, 1, 1, 700);
    repeat (10) tick(0, 1, 0, 0);
    chk("abort_count", obs.size(), 1);
    chk_obs("abort_val", 0, 169);

    // randomized runs
    for (int rnd_i = 0; rnd_i < 6; rnd_i++) begin
      rate = 8'($urandom_range(0, 255)); tick(0, 0, 0, 0);
      for (int c = 0; c < 300; c++) begin
        bit en, st;
        en = ($urandom_range(0, 99) != 0);
        st = ($urandom_range(0, 3) != 0);
        rate = 8'($urandom_range(0, 255));
        tick(0, en, st, int'($urandom_range(0, 262143)) - 131072);
      end
      repeat (8) tick(0, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/cic_decim_strobed.md
Name: cic_decim_strobed

Overview:
Programmable-rate CIC decimator that sits directly upstream of the halfband decimator in the receive DSP chain. It consumes one 18-bit signed sample per strobe_in and produces one decimated 18-bit sample per strobe_out. The output strobe/data pair connects directly to the halfband stage's strobe_in/data_in. Gain is normalised by a rate-dependent arithmetic shift, with rounding and saturation to 18 bits.

Parameters:
N, 4, number of integrator and comb stages (1..6)
WIDTH, 18, input and output sample width
MAXLOG2, 7, log2 of maximum rate; accumulator width = WIDTH + N*MAXLOG2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run; low acts as synchronous clear of all state
rate  in  8  decimation factor 1..128; 0 treated as 1; >128 treated as 128
strobe_in  in  1  input sample valid; may be high every cycle
data_in  in  WIDTH  signed input sample
strobe_out  out  1  one-cycle pulse, decimated sample valid
data_out  out  WIDTH  signed decimated sample, held between strobes

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is named clock, reset port is named reset.
- Reset, or enable=0, on a rising clock edge: all integrators, combs, the group counter and the pipeline valid bits are cleared to 0; strobe_out=0; data_out=0. The effective rate is latched from the rate port on every cycle where reset=1 or enable=0. rate changes while enabled are ignored.
- Effective rate R: clamp of the latched rate (0 becomes 1, values above 2^MAXLOG2 become 2^MAXLOG2). Shift S = N*ceil(log2(R)), so R=1 gives S=0 and R=3 gives S=2N.
- Integrators: N cascaded accumulators. All update only on strobe_in cycles. Input is sign-extended to full width. Wrap-around (two's complement overflow) is permitted and required for correctness; no saturation inside.
- Group counter: 0..R-1, advances on each strobe_in. On the strobe_in where the counter equals R-1, it wraps to 0 and the last integrator's new value is captured as a decimated sample; a valid token is launched.
- Comb chain: N registered stages, differential delay 1, full width. Each stage updates only when its valid token arrives, one cycle per stage.
- Normalise stage, one registered cycle:
  - add 2^(S-1) when S>0, then arithmetic shift right by S (round half up);
  - saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: strobe_out pulses exactly N+2 cycles after the strobe_in that completed the group. data_out updates on that same cycle.
- Back-to-back: strobe_in may be asserted every cycle with R=1. The pipeline must accept one token per cycle with no drops.
- enable dropping mid-pipeline: in-flight tokens are discarded and no strobe_out is produced.
- strobe_in high while enable=0: ignored.

Test Plan:
- Reset and idle: hold reset 10 cycles, then enable=1 with no strobes -> strobe_out stays 0 and data_out stays 0 indefinitely.
- DC, rate=4, N=4, data_in=1000 every other cycle -> strobe_out every 8 cycles; data_out reaches 1000 from the 4th output onward and holds 1000 thereafter.
- Impulse, rate=2, N=4 (S=4):
  - 4096 on input index 1, otherwise 0 -> outputs 256, 1536, 256, then 0.
  - same impulse on input index 0 -> outputs 1024, 1024, then 0.
- Bypass, rate=1 (also rate=0), strobe_in every cycle with ramp 0,1,2,... -> after transient, data_out is the ramp steady-state response. strobe_out high every cycle, first pulse exactly 6 cycles after the first strobe_in.
- Extremes, rate=8, DC -131072 then DC 131071 -> steady outputs -131072 then 131071 with no wrap. Rate=3, DC 131071 -> steady 41472 (131071*81/256, rounded).
- enable deassert mid-group, rate=4: after 2 strobes drop enable for 1 cycle, then change rate to 2 and re-enable -> no strobe_out from the aborted group. The next output appears after 2 new strobe_ins + 6 cycles, computed from cleared state.
